// File: rtl/ula_pkg.sv
// Shared ULA opcode definitions: op_sel codes, encoded opcodes and
// the request entry carried from the FIFO to the issue ports.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100
    } op_sel_e;

    localparam logic [7:0] OPC_ADD = 8'h01;
    localparam logic [7:0] OPC_SUB = 8'h02;
    localparam logic [7:0] OPC_MUL = 8'h03;
    localparam logic [7:0] OPC_DIV = 8'h04;
    localparam logic [7:0] OPC_MOD = 8'h05;

    localparam int ENTRY_W = 24;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } entry_t;

    function automatic logic sel_ok(input logic [2:0] sel);
        return (sel <= OP_MOD);
    endfunction

    function automatic logic [7:0] encode(input logic [2:0] sel);
        logic [7:0] r;
        r = 8'h00;
        case (sel)
            OP_ADD:  r = OPC_ADD;
            OP_SUB:  r = OPC_SUB;
            OP_MUL:  r = OPC_MUL;
            OP_DIV:  r = OPC_DIV;
            OP_MOD:  r = OPC_MOD;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/opcode_dispatcher_if.sv
// Request input, dual-core issue ports and status of the dispatcher.
// master drives requests and issue_ready; slave is the dispatcher.
interface opcode_dispatcher_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_sel;
    logic [7:0]    operand_a;
    logic [7:0]    operand_b;
    logic [1:0]    issue_valid;
    logic [1:0]    issue_ready;
    logic [7:0]    issue_opcode0;
    logic [7:0]    issue_opcode1;
    logic [7:0]    issue_a0;
    logic [7:0]    issue_a1;
    logic [7:0]    issue_b0;
    logic [7:0]    issue_b1;
    logic          err_invalid;
    logic [7:0]    err_count;
    logic [CW-1:0] fifo_count;

    modport master (
        output op_valid, op_sel, operand_a, operand_b, issue_ready,
        input  op_ready, issue_valid,
        input  issue_opcode0, issue_opcode1,
        input  issue_a0, issue_a1, issue_b0, issue_b1,
        input  err_invalid, err_count, fifo_count
    );

    modport slave (
        input  op_valid, op_sel, operand_a, operand_b, issue_ready,
        output op_ready, issue_valid,
        output issue_opcode0, issue_opcode1,
        output issue_a0, issue_a1, issue_b0, issue_b1,
        output err_invalid, err_count, fifo_count
    );

endinterface

// File: rtl/opcode_fifo.sv
// Synchronous request FIFO; a full FIFO refuses pushes even when
// popping in the same cycle.
module opcode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH[AW:0]);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/opcode_dispatcher.sv
// Encodes ULA requests, queues them and issues them in order to two
// cores with round-robin preference.
module opcode_dispatcher
    import ula_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    opcode_dispatcher_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          wr_e, hd_e;
    logic            push, pop, full, empty;
    logic [CW-1:0]   count;
    logic            accept, good;
    logic            rdy_q;
    logic            rr_q, rr_d;
    logic [1:0]      iv_q, iv_d;
    logic [1:0]      free, load;
    entry_t [1:0]    core_q, core_d;
    logic            err_q, err_d;
    logic [7:0]      errc_q, errc_d;

    // rdy_q keeps op_ready low until the first edge after reset drops
    assign bus.op_ready = rdy_q && !full && !reset;
    assign accept = bus.op_valid && bus.op_ready;
    assign good   = sel_ok(bus.op_sel);
    assign push   = accept && good;
    assign wr_e   = {encode(bus.op_sel), bus.operand_a, bus.operand_b};

    opcode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wr_e),
        .pop_i   (pop),
        .rdata_o (hd_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign free = ~iv_q | bus.issue_ready;

    always_comb begin
        load = 2'b00;
        pop  = 1'b0;
        rr_d = rr_q;
        if (!empty) begin
            if (free[rr_q]) begin
                load[rr_q] = 1'b1;
                pop        = 1'b1;
                rr_d       = !rr_q;
            end else if (free[!rr_q]) begin
                load[!rr_q] = 1'b1;
                pop         = 1'b1;
                rr_d        = rr_q;
            end
        end
        for (int k = 0; k < 2; k++) begin
            iv_d[k]   = load[k] | (iv_q[k] & ~bus.issue_ready[k]);
            core_d[k] = load[k] ? hd_e : core_q[k];
        end
        err_d  = accept && !good;
        errc_d = errc_q;
        if (err_d && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q  <= 1'b0;
            rr_q   <= 1'b0;
            iv_q   <= '0;
            core_q <= '0;
            err_q  <= 1'b0;
            errc_q <= '0;
        end else begin
            rdy_q  <= 1'b1;
            rr_q   <= rr_d;
            iv_q   <= iv_d;
            core_q <= core_d;
            err_q  <= err_d;
            errc_q <= errc_d;
        end
    end

    assign bus.issue_valid   = iv_q;
    assign bus.issue_opcode0 = core_q[0].opcode;
    assign bus.issue_a0      = core_q[0].a;
    assign bus.issue_b0      = core_q[0].b;
    assign bus.issue_opcode1 = core_q[1].opcode;
    assign bus.issue_a1      = core_q[1].a;
    assign bus.issue_b1      = core_q[1].b;
    assign bus.err_invalid   = err_q;
    assign bus.err_count     = errc_q;
    assign bus.fifo_count    = count;

endmodule

// File: tb/tb_opcode_dispatcher.sv
// Directed bench for opcode_dispatcher: latency, alternation, back-
// pressure, invalid codes, stalled core and mid-run reset.
module tb_opcode_dispatcher;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    opcode_dispatcher_if #(.DEPTH(4)) bus();

    opcode_dispatcher #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.op_valid    = 1'b0;
        bus.issue_ready = 2'b00;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b);
        bus.op_valid  = v;
        bus.op_sel    = s;
        bus.operand_a = a;
        bus.operand_b = b;
    endtask

    logic [7:0] exp_opc [5];
    logic [7:0] got_a[$];
    logic [7:0] got_o[$];
    int         pushed;
    logic       acc;

    initial begin
        checks = 0;
        errors = 0;
        exp_opc[0] = 8'h01; exp_opc[1] = 8'h02; exp_opc[2] = 8'h03;
        exp_opc[3] = 8'h04; exp_opc[4] = 8'h05;
        reset = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        bus.issue_ready = 2'b00;
        step();
        step();
        chk("rst_ready",  bus.op_ready, 0);
        chk("rst_valid",  bus.issue_valid, 0);
        chk("rst_err",    bus.err_invalid, 0);
        chk("rst_errcnt", bus.err_count, 0);
        chk("rst_count",  bus.fifo_count, 0);
        chk("rst_opc0",   bus.issue_opcode0, 0);
        chk("rst_a1",     bus.issue_a1, 0);
        reset = 1'b0;
        chk("rel_ready_low", bus.op_ready, 0);
        step();
        chk("rel_ready_high", bus.op_ready, 1);

        // single MUL request, two-cycle latency
        drive(1'b1, 3'b010, 8'h07, 8'h03);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        chk("lat_count1", bus.fifo_count, 1);
        chk("lat_notyet", bus.issue_valid, 0);
        step();
        chk("lat_valid", bus.issue_valid, 2'b01);
        chk("lat_opc0",  bus.issue_opcode0, 8'h03);
        chk("lat_a0",    bus.issue_a0, 8'h07);
        chk("lat_b0",    bus.issue_b0, 8'h03);
        chk("lat_count0", bus.fifo_count, 0);
        bus.issue_ready = 2'b01;
        step();
        chk("lat_drain", bus.issue_valid, 0);

        // five back-to-back ops alternate 0,1,0,1,0
        do_reset();
        bus.issue_ready = 2'b11;
        for (int j = 0; j < 6; j++) begin
            if (j < 5)
                drive(1'b1, 3'(j), 8'h10 + 8'(j), 8'h20 + 8'(j));
            else
                drive(1'b0, 3'b000, 8'h00, 8'h00);
            step();
            if (j >= 1) begin
                chk($sformatf("alt_valid%0d", j), bus.issue_valid,
                    (j % 2 == 1) ? 2'b01 : 2'b10);
                if (j % 2 == 1) begin
                    chk($sformatf("alt_opc%0d", j), bus.issue_opcode0,
                        exp_opc[j-1]);
                    chk($sformatf("alt_a%0d", j), bus.issue_a0,
                        8'h10 + 8'(j-1));
                end else begin
                    chk($sformatf("alt_opc%0d", j), bus.issue_opcode1,
                        exp_opc[j-1]);
                    chk($sformatf("alt_b%0d", j), bus.issue_b1,
                        8'h20 + 8'(j-1));
                end
            end
        end
        step();
        chk("alt_done", bus.issue_valid, 0);

        // back-pressure: cores stalled, FIFO fills at 4
        do_reset();
        pushed = 0;
        for (int c = 0; c < 10; c++) begin
            drive(pushed < 7, 3'(pushed % 5), 8'h40 + 8'(pushed),
                  8'h80 + 8'(pushed));
            acc = bus.op_valid && bus.op_ready;
            step();
            if (acc) pushed++;
        end
        chk("bp_pushed",  pushed, 6);
        chk("bp_ready",   bus.op_ready, 0);
        chk("bp_count",   bus.fifo_count, 4);
        chk("bp_valid",   bus.issue_valid, 2'b11);
        chk("bp_hold_a0", bus.issue_a0, 8'h40);
        chk("bp_hold_a1", bus.issue_a1, 8'h41);
        bus.issue_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.issue_valid[k] && bus.issue_ready[k]) begin
                    got_a.push_back(k == 0 ? bus.issue_a0 : bus.issue_a1);
                    got_o.push_back(k == 0 ? bus.issue_opcode0
                                           : bus.issue_opcode1);
                end
            end
            drive(pushed < 7, 3'(pushed % 5), 8'h40 + 8'(pushed),
                  8'h80 + 8'(pushed));
            acc = bus.op_valid && bus.op_ready;
            step();
            if (acc) pushed++;
        end
        chk("bp_total", got_a.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < got_a.size()) begin
                chk($sformatf("bp_order_a%0d", i), got_a[i], 8'h40 + 8'(i));
                chk($sformatf("bp_order_o%0d", i), got_o[i],
                    exp_opc[i % 5]);
            end
        end

        // invalid op_sel codes
        do_reset();
        bus.issue_ready = 2'b11;
        drive(1'b1, 3'b110, 8'h11, 8'h22);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        chk("inv_pulse",  bus.err_invalid, 1);
        chk("inv_cnt1",   bus.err_count, 1);
        chk("inv_nofifo", bus.fifo_count, 0);
        step();
        chk("inv_pulse_end", bus.err_invalid, 0);
        chk("inv_noissue",   bus.issue_valid, 0);
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 3'(5 + i % 3), 8'h00, 8'h00);
            step();
        end
        chk("inv_cnt255", bus.err_count, 255);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'b111, 8'h00, 8'h00);
            step();
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        chk("inv_sat",     bus.err_count, 255);
        chk("inv_sat_pls", bus.err_invalid, 1);
        chk("inv_none",    bus.issue_valid, 0);

        // core 0 stalled: later ops go to core 1
        do_reset();
        bus.issue_ready = 2'b10;
        for (int j = 0; j < 5; j++) begin
            if (j < 4)
                drive(1'b1, 3'(j), 8'h50 + 8'(j), 8'h60 + 8'(j));
            else
                drive(1'b0, 3'b000, 8'h00, 8'h00);
            step();
            if (j >= 1) begin
                chk($sformatf("stall_v0_%0d", j), bus.issue_valid[0], 1);
                chk($sformatf("stall_a0_%0d", j), bus.issue_a0, 8'h50);
                chk($sformatf("stall_o0_%0d", j), bus.issue_opcode0, 8'h01);
            end
            if (j >= 2) begin
                chk($sformatf("stall_a1_%0d", j), bus.issue_a1,
                    8'h50 + 8'(j-1));
                chk($sformatf("stall_o1_%0d", j), bus.issue_opcode1,
                    exp_opc[j-1]);
            end
        end

        // reset with three entries queued
        do_reset();
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 3'b001, 8'h70 + 8'(j), 8'h00);
            step();
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        chk("mr_count3", bus.fifo_count, 3);
        reset = 1'b1;
        bus.issue_ready = 2'b11;
        step();
        chk("mr_count0", bus.fifo_count, 0);
        chk("mr_valid0", bus.issue_valid, 0);
        chk("mr_ready0", bus.op_ready, 0);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("mr_idle%0d", j), bus.issue_valid, 0);
        end
        chk("mr_empty", bus.fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opcode_dispatcher.md
OPCODE_DISPATCHER -- requirements
Module: opcode_dispatcher

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH SHALL default to 4 and set the request FIFO depth (power of two, 2..16).
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port reset  in  1  synchronous active-high reset.
REQ-005 Port op_valid  in  1  request present.
REQ-006 Port op_ready  out  1  request accepted when op_valid&&op_ready.
REQ-007 Port op_sel  in  3  ULA operation code (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD).
REQ-008 Ports operand_a and operand_b SHALL each be in, 8 bits, carried unchanged to the issued instruction.
REQ-009 Ports issue_valid[1:0] out, issue_ready[1:0] in, issue_opcode0/1 out 8, issue_a0/1 out 8, issue_b0/1 out 8 SHALL form two per-core valid/ready issue ports.
REQ-010 Port err_invalid  out  1  one-cycle pulse on a rejected op_sel.
REQ-011 Port err_count  out  8  saturating count of rejected requests.
REQ-012 Port fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Encoding SHALL be op_sel 000->8'h01, 001->8'h02, 010->8'h03, 011->8'h04, 100->8'h05.
REQ-014 op_sel 101..111 SHALL be accepted when op_ready=1 but not written to the FIFO; err_invalid SHALL pulse the following cycle; err_count SHALL increment, saturating at 255.
REQ-015 op_ready SHALL equal (fifo_count < DEPTH); a full FIFO SHALL NOT accept a push even in a cycle with a pop.
REQ-016 Valid requests SHALL be stored encoded (opcode, a, b) and dispatched in arrival order.
REQ-017 Core k SHALL be free when !issue_valid[k] || issue_ready[k].
REQ-018 At most one entry SHALL be dispatched per cycle: to core rr_ptr if free, else to the other core if free, else none.
REQ-019 After a dispatch to core k, rr_ptr SHALL become the other core; rr_ptr SHALL be unchanged otherwise.
REQ-020 A loaded core output SHALL hold opcode, a, b and issue_valid stable until issue_ready is sampled high.
REQ-021 issue_valid[k] SHALL clear on a handshake unless a new entry is loaded into core k in the same cycle.
REQ-022 Latency SHALL be 2 cycles: an op accepted at edge N into an empty FIFO, with a free core, SHALL show issue_valid at the cycle after edge N+1.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 Sustained throughput SHALL be one instruction per cycle when both cores accept.

Reset
REQ-025 During reset, op_ready, issue_valid, err_invalid, err_count, fifo_count SHALL be 0; rr_ptr SHALL be 0; issue_opcode/a/b SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all FIFO contents and pending issues at the next edge, without completing any handshake.
REQ-027 op_ready SHALL be 0 while reset is high and rise the cycle after release.

Structure
REQ-028 The op_sel codes, opcode constants (8'h01..8'h05) and the encode function SHALL live in a shared package ula_pkg, also used by the controller.
REQ-029 The FIFO SHALL be a sub-module opcode_fifo (parameter DEPTH, WIDTH=24) with push/pop/full/empty/count.

Verification
REQ-030 Reset, then op_sel=010, a=8'h07, b=8'h03 -> 2 cycles later issue_valid[0]=1, issue_opcode0=8'h03, issue_a0=8'h07, issue_b0=8'h03.
REQ-031 Five back-to-back valid ops, both issue_ready=1 -> issued alternately to core 0,1,0,1,0, one per cycle, in order.
REQ-032 issue_ready=2'b00, push 7 ops -> op_ready falls after 4 pushes for the FIFO plus the 2 held in the cores; fifo_count=4; no data lost after release.
REQ-033 op_sel=110 -> no issue, err_invalid pulses once, err_count=1; 256 invalid ops -> err_count=255.
REQ-034 issue_ready[0]=0 held, core 0 loaded -> all subsequent ops go to core 1; core 0 outputs stay stable.
REQ-035 Reset asserted with FIFO at 3 entries -> next cycle fifo_count=0, issue_valid=0, nothing issued after release.
